// File: rtl/board_input_ctrl_pkg.sv
// Shared types and helpers for the board input controller.
//   seq_state_t : sequencer state encoding (WAIT_LOCK=0, HOLD=1, RUN=2)
//   SEQ_STATE_W : width of the seq_state debug port
//   cnt_width() : counter width for counting 0..n-1 (at least one bit)
package board_io_pkg;

  localparam int SEQ_STATE_W = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_input_ctrl_if.sv
// Board-side signal bundle of the board input controller.
//   pll_locked    : PLL lock, asynchronous to clk
//   btn_reset_raw : raw board reset button
//   btn_raw       : raw player buttons
//   core_rst_n    : active-low reset to the game core
//   btn_level     : debounced button state, 1 = pressed
//   btn_press     : single-cycle press pulses
//   seq_state     : sequencer state (debug)
// Modports: master = board/test side, slave = board_input_ctrl.
interface board_input_ctrl_if
  import board_io_pkg::*;
#(
  parameter int NUM_BTN = 5
);

  logic                   pll_locked;
  logic                   btn_reset_raw;
  logic [NUM_BTN-1:0]     btn_raw;
  logic                   core_rst_n;
  logic [NUM_BTN-1:0]     btn_level;
  logic [NUM_BTN-1:0]     btn_press;
  logic [SEQ_STATE_W-1:0] seq_state;

  modport master (
    output pll_locked, btn_reset_raw, btn_raw,
    input  core_rst_n, btn_level, btn_press, seq_state
  );

  modport slave (
    input  pll_locked, btn_reset_raw, btn_raw,
    output core_rst_n, btn_level, btn_press, seq_state
  );

endinterface

// File: rtl/board_input_ctrl_btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter and press-edge pulse.
//   clk    : system clock
//   nRESET : asynchronous active-low reset
//   raw    : button input already normalised to active-high (asynchronous)
//   level  : debounced level, 1 = pressed
//   press  : 1-cycle pulse in the cycle after level rises
// A new level is accepted only after the synchronised input has differed from
// the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 18000
) (
  input  logic clk,
  input  logic nRESET,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             stable;
  logic             stable_d;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      // synchroniser boundary: sync_p0 -> sync_p1
      sync_p0 <= raw;
      sync_p1 <= sync_p0;

      // debounce boundary: any return to the accepted level restarts the count
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // edge boundary: pulse in the cycle after stable rises, nothing on release
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

  assign level = stable;

endmodule

// File: rtl/board_input_ctrl.sv
// Board-level reset sequencer and button conditioner between the PLL and the game core.
//   clk    : system clock (PLL outclk_0)
//   nRESET : asynchronous active-low reset
//   bus    : board_input_ctrl_if.slave
//            in : pll_locked, btn_reset_raw, btn_raw[NUM_BTN]
//            out: core_rst_n, btn_level[NUM_BTN], btn_press[NUM_BTN], seq_state
// Core reset is held until PLL lock plus POR_CYCLES; lock loss or a debounced
// reset-button press re-enters reset. Player and reset buttons share one
// debounce channel type; the reset button is the extra top channel and is never
// visible on btn_level.
// Optional feature macro: BTN_AUTOREPEAT_EN adds held-button auto-repeat pulses
// (first after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
module board_input_ctrl
  import board_io_pkg::*;
#(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 18000,
  parameter int POR_CYCLES      = 65536,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 9000000,
  parameter int REPEAT_PERIOD   = 1800000
) (
  input  logic                clk,
  input  logic                nRESET,
  board_input_ctrl_if.slave   bus
);

  localparam int               POR_W   = cnt_width(POR_CYCLES);
  localparam logic [POR_W-1:0] POR_MAX = POR_W'(POR_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || POR_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_param
    $error("board_input_ctrl: cycle-count parameters must be at least 1");
  end

  // Button channels: index NUM_BTN is the board reset button.
  logic [NUM_BTN:0] raw_hi;
  logic [NUM_BTN:0] deb_level;
  logic [NUM_BTN:0] deb_press;

  assign raw_hi = {bus.btn_reset_raw, bus.btn_raw} ^ {(NUM_BTN + 1){BTN_ACTIVE_LOW != 0}};

  for (genvar g = 0; g <= NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk    (clk),
      .nRESET (nRESET),
      .raw    (raw_hi[g]),
      .level  (deb_level[g]),
      .press  (deb_press[g])
    );
  end

  logic rst_btn_level;
  logic rst_btn_press;

  assign rst_btn_level = deb_level[NUM_BTN];
  assign rst_btn_press = deb_press[NUM_BTN];

  // Lock synchroniser: lock_p0 -> lock_p1
  logic lock_p0;
  logic lock_p1;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= bus.pll_locked;
      lock_p1 <= lock_p0;
    end
  end

  // Sequencer
  seq_state_t       state;
  seq_state_t       state_next;
  logic [POR_W-1:0] por_cnt;
  logic [POR_W-1:0] por_cnt_next;
  logic             core_run;
  logic             core_run_next;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state    <= WAIT_LOCK;
      por_cnt  <= '0;
      core_run <= 1'b0;
    end else begin
      state    <= state_next;
      por_cnt  <= por_cnt_next;
      core_run <= core_run_next;
    end
  end

  always_comb begin
    state_next   = state;
    por_cnt_next = por_cnt;
    unique case (state)
      WAIT_LOCK: begin
        por_cnt_next = '0;
        if (lock_p1) state_next = HOLD;
      end
      HOLD: begin
        if (!lock_p1) begin
          state_next = WAIT_LOCK;
        end else if (rst_btn_level) begin
          // a held reset button keeps the power-on delay from starting
          por_cnt_next = '0;
        end else if (por_cnt == POR_MAX) begin
          state_next = RUN;
        end else begin
          por_cnt_next = por_cnt + 1'b1;
        end
      end
      RUN: begin
        // lock loss outranks the reset button
        if (!lock_p1) begin
          state_next = WAIT_LOCK;
        end else if (rst_btn_press) begin
          state_next   = HOLD;
          por_cnt_next = '0;
        end
      end
      default: begin
        state_next   = WAIT_LOCK;
        por_cnt_next = '0;
      end
    endcase
  end

  // Core reset releases one cycle after RUN is entered, but asserts on the same
  // edge that leaves RUN so the core never runs a cycle past lock loss.
  always_comb begin
    core_run_next = (state == RUN) && (state_next == RUN);
  end

  // Press pulses towards the core
  logic [NUM_BTN-1:0] press_src;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = cnt_width(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0]   rpt_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] rpt_armed;
  logic [NUM_BTN-1:0] rpt_pulse;

  // rpt_cnt counts cycles of held level; the first target is measured from the
  // level rise, so the first repeat lands REPEAT_DELAY after the edge pulse.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < NUM_BTN; i++) rpt_cnt[i] <= '0;
      rpt_armed <= '0;
      rpt_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!deb_level[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_armed[i] <= 1'b0;
          rpt_pulse[i] <= 1'b0;
        end else if (rpt_cnt[i] == (rpt_armed[i] ? RPT_NEXT : RPT_FIRST)) begin
          rpt_cnt[i]   <= '0;
          rpt_armed[i] <= 1'b1;
          rpt_pulse[i] <= 1'b1;
        end else begin
          rpt_cnt[i]   <= rpt_cnt[i] + 1'b1;
          rpt_pulse[i] <= 1'b0;
        end
      end
    end
  end

  assign press_src = deb_press[NUM_BTN-1:0] | rpt_pulse;
`else
  assign press_src = deb_press[NUM_BTN-1:0];
`endif

  // Levels stay live through core reset; presses are suppressed while it is held.
  assign bus.btn_level  = deb_level[NUM_BTN-1:0];
  assign bus.btn_press  = press_src & {NUM_BTN{core_run}};
  assign bus.core_rst_n = core_run;
  assign bus.seq_state  = state;

endmodule
